// File: rtl/sega_pad_pkg.sv
// Shared definitions for the Sega 3-button pad reader: pin indices on the
// synchronized pad bus, FSM state encoding, button vector layout and the
// helper that assembles a button vector from the two SELECT phases.
package sega_pad_pkg;

    // Bit positions of the pad pins on pad_in / the synchronized bus.
    // With SELECT high, pins 1..4 carry Up/Down/Left/Right and pins 6/9
    // carry B/C. With SELECT low, pins 3/4 are grounded by a connected pad
    // and pins 6/9 carry A/Start.
    localparam int PIN_UP    = 0;   // pin 1
    localparam int PIN_DOWN  = 1;   // pin 2
    localparam int PIN_LEFT  = 2;   // pin 3
    localparam int PIN_RIGHT = 3;   // pin 4
    localparam int PIN_6     = 4;   // pin 6: B (SELECT high) / A (SELECT low)
    localparam int PIN_9     = 5;   // pin 9: C (SELECT high) / Start (SELECT low)

    localparam int PAD_W = 6;

    // Button vector bit order: {start, c, b, a, right, left, down, up}.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;

    localparam int BTN_W = 8;

    // SELECT phase states; the state bit doubles as the inverse of pad_select.
    localparam logic [0:0] SEL_HI = 1'b0;
    localparam logic [0:0] SEL_LO = 1'b1;

    typedef logic [BTN_W-1:0] btn_vec_t;

    // One evaluated pad frame.
    typedef struct packed {
        logic     present;
        btn_vec_t btn;
    } frame_t;

    // Nothing connected, nothing pressed.
    localparam frame_t FRAME_RELEASED = '0;

    // Merge the SELECT-high capture (already active-high, indexed like the
    // pins) with the A/Start bits seen during SELECT low.
    function automatic btn_vec_t pack_buttons(
        input logic [PAD_W-1:0] hi,
        input logic             a,
        input logic             start
    );
        btn_vec_t v;
        v            = '0;
        v[BTN_UP]    = hi[PIN_UP];
        v[BTN_DOWN]  = hi[PIN_DOWN];
        v[BTN_LEFT]  = hi[PIN_LEFT];
        v[BTN_RIGHT] = hi[PIN_RIGHT];
        v[BTN_B]     = hi[PIN_6];
        v[BTN_C]     = hi[PIN_9];
        v[BTN_A]     = a;
        v[BTN_START] = start;
        return v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable
// reset value so idle (released) pins come out of reset in their idle state.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset2,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the input through two flops to settle metastability.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so q takes the old meta, giving two real stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sega_pad_reader.sv
// Host-side reader for a 3-button Sega Genesis pad. Alternates the SELECT
// line every PHASE_CYCLES clocks, samples the synchronized pins at the end of
// each phase, builds one raw frame per SELECT-high/low pair, debounces whole
// frames and presents active-high buttons plus a start edge pulse.
module sega_pad_reader
    import sega_pad_pkg::*;
#(
    parameter int PHASE_CYCLES = 25000,
    parameter int DB_FRAMES    = 4
) (
    input  logic             clk,
    input  logic             reset2,
    input  logic [PAD_W-1:0] pad_in,
    output logic             pad_select,
    output logic             btn_up,
    output logic             btn_down,
    output logic             btn_left,
    output logic             btn_right,
    output logic             btn_a,
    output logic             btn_b,
    output logic             btn_c,
    output logic             btn_start,
    output logic             start_pulse,
    output logic             pad_present,
    output logic             frame_tick
);

    localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int AG_W  = $clog2(DB_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [AG_W-1:0]  AG_MAX   = AG_W'(DB_FRAMES - 1);

    logic [PAD_W-1:0] pad_sync;
    logic [0:0]       state;
    logic [CNT_W-1:0] phase_cnt;
    logic [PAD_W-1:0] hi_q;
    logic             phase_end;
    logic             frame_end;
    logic             present_raw;
    frame_t           raw_frame;
    frame_t           prev_frame;
    logic [AG_W-1:0]  agree_cnt;
    logic [AG_W-1:0]  agree_next;
    btn_vec_t         btn_q;
    logic             present_q;

    // Pins idle high, so the synchronizer resets to all-released.
    sync_2ff #(
        .WIDTH     (PAD_W),
        .RESET_VAL ({PAD_W{1'b1}})
    ) u_pad_sync (
        .clk    (clk),
        .reset2 (reset2),
        .d      (pad_in),
        .q      (pad_sync)
    );

    assign phase_end = (phase_cnt == CNT_LAST);
    assign frame_end = phase_end && (state == SEL_LO);

    // Phase counter and SELECT FSM: each phase lasts exactly PHASE_CYCLES clocks.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            state     <= SEL_HI;
            phase_cnt <= '0;
        end else if (phase_end) begin
            phase_cnt <= '0;
            state     <= (state == SEL_HI) ? SEL_LO : SEL_HI;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Register-driven SELECT, so an async reset forces it high immediately.
    assign pad_select = (state == SEL_HI);

    // Capture the SELECT-high half of the frame, inverted to active-high.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            hi_q <= '0;
        end else if (phase_end && (state == SEL_HI)) begin
            hi_q <= ~pad_sync;
        end
    end

    // A connected pad grounds pins 3 and 4 while SELECT is low.
    assign present_raw = ~pad_sync[PIN_LEFT] & ~pad_sync[PIN_RIGHT];

    // Assemble the raw frame from the held high half and the live low half.
    always_comb begin
        // NOTE: default every field first so no path leaves raw_frame unassigned (no latch).
        raw_frame         = FRAME_RELEASED;
        raw_frame.present = present_raw;
        if (present_raw) begin
            raw_frame.btn = pack_buttons(hi_q, ~pad_sync[PIN_6], ~pad_sync[PIN_9]);
        end
    end

    // Saturating count of consecutive frames identical to the previous one.
    always_comb begin
        agree_next = '0;
        if (raw_frame == prev_frame) begin
            agree_next = (agree_cnt == AG_MAX) ? agree_cnt : agree_cnt + 1'b1;
        end
    end

    // Debounce at frame end: outputs load once DB_FRAMES frames in a row agree.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            prev_frame  <= FRAME_RELEASED;
            agree_cnt   <= '0;
            btn_q       <= '0;
            present_q   <= 1'b0;
            start_pulse <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick  <= frame_end;
            start_pulse <= 1'b0;
            if (frame_end) begin
                prev_frame <= raw_frame;
                agree_cnt  <= agree_next;
                if (agree_next == AG_MAX) begin
                    btn_q       <= raw_frame.btn;
                    present_q   <= raw_frame.present;
                    start_pulse <= raw_frame.btn[BTN_START] & ~btn_q[BTN_START];
                end
            end
        end
    end

    assign btn_up      = btn_q[BTN_UP];
    assign btn_down    = btn_q[BTN_DOWN];
    assign btn_left    = btn_q[BTN_LEFT];
    assign btn_right   = btn_q[BTN_RIGHT];
    assign btn_a       = btn_q[BTN_A];
    assign btn_b       = btn_q[BTN_B];
    assign btn_c       = btn_q[BTN_C];
    assign btn_start   = btn_q[BTN_START];
    assign pad_present = present_q;

endmodule

// File: tb/tb_sega_pad_reader.sv
// Self-checking bench for sega_pad_reader. A pad model drives pin levels for
// each SELECT phase; a frame-level reference model predicts the debounced
// outputs and pushes them into a scoreboard that a monitor drains on every
// frame_tick while also checking SELECT timing and output stability.
module tb_sega_pad_reader;

    localparam int PHASE = 8;
    localparam int DB    = 2;
    localparam int FRAME = 2 * PHASE;

    typedef struct packed {
        logic [8:0] out;    // {present, start, c, b, a, right, left, down, up}
        logic       pulse;
    } exp_t;

    logic       clk;
    logic       reset2;
    logic [5:0] pad_in;
    logic       pad_select;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       btn_a, btn_b, btn_c, btn_start;
    logic       start_pulse, pad_present, frame_tick;

    logic [5:0] hi_pins;
    logic [5:0] lo_pins;
    int unsigned n;          // rising edges since reset release
    bit         chk_en;
    int         checks;
    int         errors;

    exp_t       sb_q[$];
    logic [8:0] hist[$];
    logic [8:0] model_out;
    logic [8:0] disp;

    sega_pad_reader #(
        .PHASE_CYCLES (PHASE),
        .DB_FRAMES    (DB)
    ) dut (
        .clk         (clk),
        .reset2      (reset2),
        .pad_in      (pad_in),
        .pad_select  (pad_select),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_a       (btn_a),
        .btn_b       (btn_b),
        .btn_c       (btn_c),
        .btn_start   (btn_start),
        .start_pulse (start_pulse),
        .pad_present (pad_present),
        .frame_tick  (frame_tick)
    );

    // The pad multiplexes its pins on SELECT like the real 74HC157 inside it.
    assign pad_in = pad_select ? hi_pins : lo_pins;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset2) begin
        if (!reset2) n <= 0;
        else         n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pin levels a real pad presents for a button set {start,c,b,a,r,l,d,u}.
    function automatic logic [11:0] pins_for(input logic conn, input logic [7:0] b);
        logic [5:0] hi;
        logic [5:0] lo;
        if (!conn) begin
            hi = 6'h3F;
            lo = 6'h3F;
        end else begin
            hi = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
            lo = ~{b[7], b[4], 1'b1, 1'b1, b[1], b[0]};
        end
        return {hi, lo};
    endfunction

    // Decode pin levels into {present, buttons} straight from the pad pinout.
    function automatic logic [8:0] decode(input logic [5:0] hi, input logic [5:0] lo);
        logic present;
        present = !lo[2] && !lo[3];
        if (!present) return 9'd0;
        return {1'b1, !lo[5], !hi[5], !hi[4], !lo[4], !hi[3], !hi[2], !hi[1], !hi[0]};
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(9'd0);
        model_out = 9'd0;
    endtask

    // Outputs follow the raw frame once the last DB frames are all identical.
    task automatic model_push(input logic [5:0] hi, input logic [5:0] lo);
        logic [8:0] raw;
        logic [8:0] nxt;
        bit         same;
        exp_t       e;
        raw = decode(hi, lo);
        hist.push_back(raw);
        if (hist.size() > DB) void'(hist.pop_front());
        same = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != raw) same = 0;
        nxt     = same ? raw : model_out;
        e.out   = nxt;
        e.pulse = nxt[7] & ~model_out[7];
        sb_q.push_back(e);
        model_out = nxt;
    endtask

    // Wait for the quiet point of the next frame, apply its pins, predict it.
    task automatic do_frame(input logic [5:0] hi, input logic [5:0] lo);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((n % FRAME != 2) && waited < 3 * FRAME);
        if (n % FRAME != 2) begin
            checks++;
            errors++;
            $display("FAIL frame_align: edge count %0d, required phase offset 2", n);
        end
        hi_pins = hi;
        lo_pins = lo;
        model_push(hi, lo);
    endtask

    task automatic pad_frame(input logic conn, input logic [7:0] b);
        logic [11:0] p;
        p = pins_for(conn, b);
        do_frame(p[11:6], p[5:0]);
    endtask

    // Monitor: SELECT timing, frame_tick cadence, scoreboard and stable outputs.
    initial begin
        exp_t e;
        logic [8:0] outs;
        forever begin
            @(negedge clk);
            if (chk_en && reset2) begin
                check("pad_select", 32'(pad_select), 32'((n % FRAME) < PHASE));
                check("frame_tick", 32'(frame_tick), 32'((n != 0) && (n % FRAME == 0)));
                if (frame_tick) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: frame_tick with no expected frame queued");
                    end else begin
                        e    = sb_q.pop_front();
                        disp = e.out;
                        check("start_pulse", 32'(start_pulse), 32'(e.pulse));
                    end
                end else begin
                    check("start_pulse_idle", 32'(start_pulse), 32'd0);
                end
                outs = {pad_present, btn_start, btn_c, btn_b, btn_a,
                        btn_right, btn_left, btn_down, btn_up};
                check("outputs", 32'(outs), 32'(disp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int held;
        int kind;
        logic [7:0]  b;
        logic [11:0] p;
        logic [5:0]  rh;
        logic [5:0]  rl;
        int waited;
        logic [8:0] outs;

        checks  = 0;
        errors  = 0;
        chk_en  = 0;
        disp    = 9'd0;
        hi_pins = 6'h3F;
        lo_pins = 6'h3F;
        reset2  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_select", 32'(pad_select), 32'd1);
        reset2 = 1'b1;
        chk_en = 1;

        // Constant 110011: present, Left+Right together, held two frames.
        do_frame(6'b110011, 6'b110011);
        do_frame(6'b110011, 6'b110011);
        // No pad.
        pad_frame(1'b0, 8'h00);
        pad_frame(1'b0, 8'h00);
        // Idle pad.
        pad_frame(1'b1, 8'h00);
        pad_frame(1'b1, 8'h00);
        // A + Start held three frames.
        pad_frame(1'b1, 8'h90);
        pad_frame(1'b1, 8'h90);
        pad_frame(1'b1, 8'h90);
        // Right for a single frame, then held two.
        pad_frame(1'b1, 8'h08);
        pad_frame(1'b1, 8'h00);
        pad_frame(1'b1, 8'h08);
        pad_frame(1'b1, 8'h08);

        // Random pad activity with holds of one to three frames.
        for (int i = 0; i < 40; i++) begin
            held = $urandom_range(1, 3);
            kind = $urandom_range(0, 9);
            b    = 8'($urandom);
            p    = pins_for(kind != 0, b);
            rh   = 6'($urandom);
            rl   = 6'($urandom);
            for (int j = 0; j < held; j++) begin
                if (kind == 1) do_frame(rh, rl);
                else           do_frame(p[11:6], p[5:0]);
            end
        end

        // B held, then reset in the middle of SELECT low.
        pad_frame(1'b1, 8'h20);
        pad_frame(1'b1, 8'h20);
        pad_frame(1'b1, 8'h20);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((n % FRAME != PHASE + 3) && waited < 3 * FRAME);
        check("btn_b_before_reset", 32'(btn_b), 32'd1);
        #2;
        chk_en = 0;
        reset2 = 1'b0;
        #1;
        outs = {pad_present, btn_start, btn_c, btn_b, btn_a,
                btn_right, btn_left, btn_down, btn_up};
        check("midreset_select", 32'(pad_select), 32'd1);
        check("midreset_outputs", 32'(outs), 32'd0);
        check("midreset_pulse", 32'(start_pulse), 32'd0);
        check("midreset_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(negedge clk);
        sb_q.delete();
        model_reset();
        disp   = 9'd0;
        reset2 = 1'b1;
        chk_en = 1;

        pad_frame(1'b1, 8'h20);
        pad_frame(1'b1, 8'h20);
        pad_frame(1'b1, 8'h20);
        repeat (FRAME + 4) @(negedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
